alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute-stage ALU. Consumes the 4-bit Operation code produced by the ALU controller plus two operands.
//  Returns a registered ALUResult/Zero pair over valid/ready handshakes.
//  Shifts are iterative (1 bit/cycle); all other ops complete in one cycle.
//  Sits between the ID/EX register and the EX/MEM register. Branch compare results feed the PC-select logic.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width; shift amount width SW = $clog2(DATA_WIDTH)
// PORTS
//  clk        in   1           rising-edge clock
//  reset      in   1           asynchronous, active-high reset
//  in_valid   in   1           Operation/SrcA/SrcB valid
//  in_ready   out  1           unit can accept a new op this cycle
//  Operation  in   4           ALU op code (table below)
//  SrcA       in   DATA_WIDTH  operand A (rs1)
//  SrcB       in   DATA_WIDTH  operand B (rs2 or imm); SrcB[SW-1:0] = shift amount
//  out_valid  out  1           ALUResult/Zero valid
//  out_ready  in   1           downstream accepts result
//  ALUResult  out  DATA_WIDTH  registered result
//  Zero       out  1           registered (ALUResult == 0)
// BEHAVIOUR
//  Op codes:
//   0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0110 XOR, 1001 NOR(~(A|B))
//   0101 SLT/BLT (signed A<B ? 1 : 0), 1100 SLTU (unsigned), 1010 BEQ (A==B), 1011 BNE (A!=B)
//   0100 SLL, 0111 SRL, 1000 SRA
//   1101-1111 -> result 0
//  Arithmetic: ADD/SUB wrap modulo 2^DATA_WIDTH, no overflow flag. Compares zero-extend the 1-bit flag.
//  Reset (async): state=IDLE, out_valid=0, ALUResult=0, Zero=0 (Zero reflects reset result as 0 defined, not 1).
//  Accept: in_valid & in_ready at rising edge; operands and Operation latched internally.
//  in_ready = (state==IDLE) & (~out_valid | out_ready); same-cycle drain+accept allowed (back-to-back throughput 1/cycle).
//  FSM:
//   IDLE  --accept non-shift--> IDLE, out_valid=1 next cycle (latency 1).
//   IDLE  --accept shift, amt k>0--> SHIFT. cnt=k, acc=SrcA; each cycle acc shifted 1 bit, cnt--.
//   SHIFT --cnt==1--> IDLE with ALUResult=final acc, out_valid=1. Shift of k has latency 1+k cycles.
//   shift with k==0 -> treated as non-shift (latency 1, result=SrcA).
//   SRA fills with latched SrcA[DATA_WIDTH-1]; SRL/SLL fill with 0. Only SrcB[SW-1:0] used.
//  Output hold: while out_valid & ~out_ready, ALUResult/Zero stable; in_ready=0.
//  out_valid clears on out_ready unless a new result loads in the same edge.
//  Inputs ignored when in_ready=0 (no buffering beyond the one result register).
//  Zero is computed from the value loaded into ALUResult, same edge.
//  Reset mid-SHIFT: shift aborted, no result produced, state IDLE.
// TESTING
//  ADD 0x7FFFFFFF+1 -> 0x80000000, Zero=0, out_valid 1 cycle after accept. SUB 5-5 -> 0, Zero=1.
//  SLT A=0xFFFFFFFF,B=1 -> 1. SLTU same -> 0. BEQ 7,7 -> 1. BNE 7,7 -> 0 (Zero=1).
//  SRA A=0x80000000, B=4 -> 0xF8000000 after 5 cycles, in_ready=0 for 4 cycles. SLL by 0 -> A, 1 cycle.
//  out_ready held low 3 cycles with new in_valid -> in_ready=0, ALUResult stable; release -> next op accepted same edge.
//  Streaming 4 AND/OR/XOR/NOR ops with out_ready=1 -> one result per cycle, in order.
//  Assert reset during SRL by 20 (cycle 10) -> out_valid=0, ALUResult=0 immediately; next op runs normally.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with a valid/ready handshake on both sides and one registered result.
// Shifts run one bit per cycle; every other op completes in a single cycle.
module alu_exec_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero
);

  localparam int SW = $clog2(DATA_WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1010;
  localparam logic [3:0] OP_BNE  = 4'b1011;
  localparam logic [3:0] OP_SLTU = 4'b1100;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  zero_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [SW-1:0]         cnt_q;
  logic [3:0]            op_q;

  logic [DATA_WIDTH-1:0] result_d;
  logic [DATA_WIDTH-1:0] acc_d;
  logic [SW-1:0]         amt;
  logic                  is_shift;
  logic                  accept;

  assign amt      = SrcB[SW-1:0];
  assign is_shift = (Operation == OP_SLL) || (Operation == OP_SRL) || (Operation == OP_SRA);
  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign out_valid = out_valid_q;
  assign ALUResult = result_q;
  assign Zero      = zero_q;

  // Single-cycle result; a shift by zero passes SrcA straight through.
  always_comb begin
    result_d = '0;
    case (Operation)
      OP_AND:  result_d = SrcA & SrcB;
      OP_OR:   result_d = SrcA | SrcB;
      OP_ADD:  result_d = SrcA + SrcB;
      OP_SUB:  result_d = SrcA - SrcB;
      OP_XOR:  result_d = SrcA ^ SrcB;
      OP_NOR:  result_d = ~(SrcA | SrcB);
      OP_SLT:  result_d = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_SLTU: result_d = {{(DATA_WIDTH-1){1'b0}}, (SrcA < SrcB)};
      OP_BEQ:  result_d = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
      OP_BNE:  result_d = {{(DATA_WIDTH-1){1'b0}}, (SrcA != SrcB)};
      OP_SLL, OP_SRL, OP_SRA: result_d = SrcA;
      default: result_d = '0;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    case (op_q)
      OP_SLL:  acc_d = {acc_q[DATA_WIDTH-2:0], 1'b0};
      OP_SRL:  acc_d = {1'b0, acc_q[DATA_WIDTH-1:1]};
      OP_SRA:  acc_d = {acc_q[DATA_WIDTH-1], acc_q[DATA_WIDTH-1:1]};
      default: acc_d = acc_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
    end else begin
      if (out_ready) out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_shift && (amt != '0)) begin
              state_q <= SHIFT;
              acc_q   <= SrcA;
              cnt_q   <= amt;
              op_q    <= Operation;
            end else begin
              result_q    <= result_d;
              zero_q      <= (result_d == '0);
              out_valid_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - SW'(1);
          // Last step lands directly in the result register.
          if (cnt_q == SW'(1)) begin
            result_q    <= acc_d;
            zero_q      <= (acc_d == '0);
            out_valid_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit: op results, latency, backpressure, streaming, reset abort.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALUResult(ALUResult), .Zero(Zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op with out_ready high, then measure latency and in_ready-low cycles.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input logic exp_zero,
                        input int exp_lat, input int exp_busy);
    int lat;
    int busy;
    Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
    #1;
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    busy = 0;
    while (!out_valid && lat < 40) begin
      if (!in_ready) busy++;
      tick();
      lat++;
    end
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " result"}, ALUResult, exp_res);
    check({tag, " zero"}, 32'(Zero), 32'(exp_zero));
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    if (exp_busy > 0) check({tag, " busy"}, 32'(busy), 32'(exp_busy));
    tick();
    check({tag, " drained"}, 32'(out_valid), 32'd0);
  endtask

  logic [3:0]  s_op  [4];
  logic [31:0] s_a   [4];
  logic [31:0] s_b   [4];
  logic [31:0] s_exp [4];

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    Operation = '0; SrcA = '0; SrcB = '0;
    tick(); tick();
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst result", ALUResult, 32'd0);
    check("rst zero", 32'(Zero), 32'd0);
    reset = 1'b0;
    tick();
    check("idle in_ready", 32'(in_ready), 32'd1);

    run_op("ADD",   4'b0010, 32'h7FFF_FFFF, 32'h1,      32'h8000_0000, 1'b0, 1, 0);
    run_op("SUB",   4'b0011, 32'd5,         32'd5,      32'h0,         1'b1, 1, 0);
    run_op("SLT",   4'b0101, 32'hFFFF_FFFF, 32'h1,      32'h1,         1'b0, 1, 0);
    run_op("SLTU",  4'b1100, 32'hFFFF_FFFF, 32'h1,      32'h0,         1'b1, 1, 0);
    run_op("BEQ",   4'b1010, 32'd7,         32'd7,      32'h1,         1'b0, 1, 0);
    run_op("BNE",   4'b1011, 32'd7,         32'd7,      32'h0,         1'b1, 1, 0);
    run_op("AND",   4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1, 0);
    run_op("NOR",   4'b1001, 32'h0,         32'h0,      32'hFFFF_FFFF, 1'b0, 1, 0);
    run_op("OP1101",4'b1101, 32'h1234_5678, 32'h1,      32'h0,         1'b1, 1, 0);
    run_op("SRA4",  4'b1000, 32'h8000_0000, 32'd4,      32'hF800_0000, 1'b0, 5, 4);
    run_op("SLL0",  4'b0100, 32'h1234_5678, 32'd0,      32'h1234_5678, 1'b0, 1, 0);
    run_op("SLLamt",4'b0100, 32'h1,         32'h21,     32'h2,         1'b0, 2, 1);
    run_op("SRL31", 4'b0111, 32'h8000_0000, 32'd31,     32'h1,         1'b0, 32, 31);
    run_op("SRA1",  4'b1000, 32'h4000_0000, 32'd1,      32'h2000_0000, 1'b0, 2, 1);

    // Backpressure: result held while out_ready is low, next op accepted on release edge.
    Operation = 4'b0010; SrcA = 32'd1; SrcB = 32'd2; in_valid = 1'b1;
    tick();
    out_ready = 1'b0;
    Operation = 4'b0011; SrcA = 32'd10; SrcB = 32'd3;
    #1;
    check("bp in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp hold", ALUResult, 32'd3);
      check("bp valid", 32'(out_valid), 32'd1);
      check("bp stall", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp release ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp next valid", 32'(out_valid), 32'd1);
    check("bp next result", ALUResult, 32'd7);
    tick();
    check("bp drained", 32'(out_valid), 32'd0);

    // Streaming: one result per cycle, in order.
    s_op[0] = 4'b0000; s_a[0] = 32'hFF00_FF00; s_b[0] = 32'h0F0F_0F0F; s_exp[0] = 32'h0F00_0F00;
    s_op[1] = 4'b0001; s_a[1] = 32'hFF00_0000; s_b[1] = 32'h0000_00FF; s_exp[1] = 32'hFF00_00FF;
    s_op[2] = 4'b0110; s_a[2] = 32'hAAAA_AAAA; s_b[2] = 32'hFFFF_0000; s_exp[2] = 32'h5555_AAAA;
    s_op[3] = 4'b1001; s_a[3] = 32'hF0F0_F0F0; s_b[3] = 32'h0000_0F0F; s_exp[3] = 32'h0F0F_0000;
    for (int i = 0; i < 4; i++) begin
      Operation = s_op[i]; SrcA = s_a[i]; SrcB = s_b[i]; in_valid = 1'b1;
      tick();
      check("stream valid", 32'(out_valid), 32'd1);
      check("stream result", ALUResult, s_exp[i]);
    end
    in_valid = 1'b0;
    tick();
    check("stream drained", 32'(out_valid), 32'd0);

    // Reset mid-shift aborts the op with no result.
    Operation = 4'b0111; SrcA = 32'hFFFF_FFFF; SrcB = 32'd20; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("srl busy", 32'(in_ready), 32'd0);
    reset = 1'b1;
    #1;
    check("abort valid", 32'(out_valid), 32'd0);
    check("abort result", ALUResult, 32'd0);
    check("abort zero", 32'(Zero), 32'd0);
    check("abort ready", 32'(in_ready), 32'd1);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    check("abort no result", 32'(out_valid), 32'd0);
    run_op("post-rst ADD", 4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
